// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the unified-memory port arbiter:
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - arb_state_t             : arbiter FSM states
//   - grant_src_t             : which requester wins arbitration in a cycle
//   - sat_inc32               : saturating 32-bit increment used by counters
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Arbiter FSM. DONE is a one-cycle bubble after every completed access.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Grant source selected in IDLE.
  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_INSTR = 2'd1,
    SRC_DATA  = 2'd2
  } grant_src_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three handshakes around the arbiter:
//   fetch port : instr_read, instr_addr  -> instr_rdata, instr_ready
//   data port  : data_read, data_write, data_addr, data_wdata
//                                        -> data_rdata, data_ready
//   memory     : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
// Modports:
//   master : the environment (pipeline requesters plus memory model)
//   slave  : the arbiter itself
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Fetch port
  logic              instr_read;
  logic [ADDR_W-1:0] instr_addr;
  logic [DATA_W-1:0] instr_rdata;
  logic              instr_ready;

  // Data port
  logic              data_read;
  logic              data_write;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ready;

  // Memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output instr_read, instr_addr,
    output data_read, data_write, data_addr, data_wdata,
    output mem_rdata, mem_ack,
    input  instr_rdata, instr_ready,
    input  data_rdata, data_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  instr_read, instr_addr,
    input  data_read, data_write, data_addr, data_wdata,
    input  mem_rdata, mem_ack,
    output instr_rdata, instr_ready,
    output data_rdata, data_ready,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_stats.sv
// -----------------------------------------------------------------------------
// mem_arb_stats
// Saturating 32-bit event counters for the memory port arbiter.
// Only instantiated when MEM_ARB_STATS_EN is defined.
// Ports:
//   clk, rst           : clock, synchronous active-high reset (clears counters)
//   instr_grant        : one-cycle pulse per fetch grant
//   data_grant         : one-cycle pulse per data grant
//   fetch_wait         : high in every cycle a fetch is pending without ready
//   stat_instr_grants  : number of fetch grants
//   stat_data_grants   : number of data grants
//   stat_fetch_wait    : number of fetch-waiting cycles
// -----------------------------------------------------------------------------
module mem_arb_stats
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_grant,
  input  logic        data_grant,
  input  logic        fetch_wait,
  output logic [31:0] stat_instr_grants,
  output logic [31:0] stat_data_grants,
  output logic [31:0] stat_fetch_wait
);

  // Counter bank; each counter sticks at its maximum value.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_instr_grants <= 32'd0;
      stat_data_grants  <= 32'd0;
      stat_fetch_wait   <= 32'd0;
    end else begin
      if (instr_grant) begin
        stat_instr_grants <= sat_inc32(stat_instr_grants);
      end
      if (data_grant) begin
        stat_data_grants <= sat_inc32(stat_data_grants);
      end
      if (fetch_wait) begin
        stat_fetch_wait <= sat_inc32(stat_fetch_wait);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the pipeline's instruction
// fetch port and its data port. Accesses are serialised onto one memory
// handshake; data wins arbitration unless the fetch port has already been
// passed over STARVE_LIMIT times in a row, in which case fetch is forced.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset; abandons any access in flight
//   bus        : mem_port_arbiter_if.slave (fetch, data and memory handshakes)
//   stat_*     : 32-bit saturating statistics, present only with
//                MEM_ARB_STATS_EN defined
//
// Parameters:
//   ADDR_W, DATA_W : bus widths (must match the interface instance)
//   STARVE_LIMIT   : consecutive data grants tolerated while fetch waits (>=1)
//
// Timing: a request seen in IDLE at edge N raises mem_req after N; a
// zero-latency ack is sampled at N+1 and the ready pulse follows; the DONE
// bubble means the next grant is at N+3 at the earliest.
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
)(
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_instr_grants,
  output logic [31:0]       stat_data_grants,
  output logic [31:0]       stat_fetch_wait
`endif
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  arb_state_t      state_r;
  logic [SC_W-1:0] starve_cnt_r;
  grant_src_t      grant_s;
  logic            data_pend_s;
  logic            starve_full_s;

  // A simultaneous read and write request is a single data request.
  assign data_pend_s   = bus.data_read | bus.data_write;
  assign starve_full_s = (starve_cnt_r == STARVE_MAX);

  // Arbitration decision; only meaningful while IDLE.
  always_comb begin
    grant_s = SRC_NONE;
    if (state_r == IDLE) begin
      if (data_pend_s && !(bus.instr_read && starve_full_s)) begin
        grant_s = SRC_DATA;
      end else if (bus.instr_read) begin
        grant_s = SRC_INSTR;
      end else begin
        grant_s = SRC_NONE;
      end
    end else begin
      grant_s = SRC_NONE;
    end
  end

  // FSM plus all registered outputs toward the requesters and memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= {ADDR_W{1'b0}};
      bus.mem_wdata   <= {DATA_W{1'b0}};
      bus.instr_rdata <= {DATA_W{1'b0}};
      bus.instr_ready <= 1'b0;
      bus.data_rdata  <= {DATA_W{1'b0}};
      bus.data_ready  <= 1'b0;
    end else begin
      // Ready outputs are single-cycle pulses.
      bus.instr_ready <= 1'b0;
      bus.data_ready  <= 1'b0;
      case (state_r)
        IDLE: begin
          case (grant_s)
            SRC_DATA: begin
              bus.mem_req   <= 1'b1;
              // read+write together is treated as a write
              bus.mem_we    <= bus.data_write;
              bus.mem_addr  <= bus.data_addr;
              bus.mem_wdata <= bus.data_wdata;
              state_r       <= BUSY_D;
            end
            SRC_INSTR: begin
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.instr_addr;
              bus.mem_wdata <= {DATA_W{1'b0}};
              state_r       <= BUSY_I;
            end
            default: begin
              state_r <= IDLE;
            end
          endcase
        end
        BUSY_I: begin
          if (bus.mem_ack) begin
            bus.mem_req     <= 1'b0;
            bus.instr_rdata <= bus.mem_rdata;
            bus.instr_ready <= 1'b1;
            state_r         <= DONE;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            bus.mem_req    <= 1'b0;
            // stores leave the last load result untouched
            if (!bus.mem_we) begin
              bus.data_rdata <= bus.mem_rdata;
            end
            bus.data_ready <= 1'b1;
            state_r        <= DONE;
          end
        end
        DONE: begin
          // bubble: requests are deliberately not looked at here
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Starvation counter: data grants passed over a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {SC_W{1'b0}};
    end else if (state_r == IDLE) begin
      if ((grant_s == SRC_INSTR) || !bus.instr_read) begin
        starve_cnt_r <= {SC_W{1'b0}};
      end else if ((grant_s == SRC_DATA) && !starve_full_s) begin
        starve_cnt_r <= starve_cnt_r + SC_W'(1'b1);
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic instr_grant_s;
  logic data_grant_s;
  logic fetch_wait_s;

  assign instr_grant_s = (grant_s == SRC_INSTR);
  assign data_grant_s  = (grant_s == SRC_DATA);
  assign fetch_wait_s  = bus.instr_read & ~bus.instr_ready;

  mem_arb_stats u_stats (
    .clk               (clk),
    .rst               (rst),
    .instr_grant       (instr_grant_s),
    .data_grant        (data_grant_s),
    .fetch_wait        (fetch_wait_s),
    .stat_instr_grants (stat_instr_grants),
    .stat_data_grants  (stat_data_grants),
    .stat_fetch_wait   (stat_fetch_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: directed scenarios (reset, fetch,
// slow store, read+write collision, mid-access reset, contention) followed by
// randomized traffic, all compared cycle by cycle against a behavioural model.
// Statistics checks are active when MEM_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mips_mem_pkg::*;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] stat_instr_grants;
  logic [31:0] stat_data_grants;
  logic [31:0] stat_fetch_wait;
`endif

  mem_port_arbiter #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .stat_instr_grants (stat_instr_grants),
    .stat_data_grants  (stat_data_grants),
    .stat_fetch_wait   (stat_fetch_wait)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [0:15];
  function automatic int midx(input logic [31:0] a);
    return int'({a[22], a[4:2]});
  endfunction

  int lat_min = 0, lat_max = 0, ack_cnt = 0;
  bit req_seen = 0, force_ack = 0, prev_req = 0;

  // ---------------- reference model state ----------------
  int          m_phase  = 0;     // 0 free, 1 access outstanding, 2 bubble
  bit          m_port_d = 0;
  int          m_starve = 0;
  logic        e_req = 0, e_we = 0, e_irdy = 0, e_drdy = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_irdata = 0, e_drdata = 0;
  logic [31:0] fw = 0, sg_i = 0, sg_d = 0;
  bit          grant_log [$];    // 1 = fetch granted

  // requester state for generated traffic
  bit i_act = 0, d_act = 0, i_blk = 0, d_blk = 0;

  // One clock: capture inputs, advance DUT and model, compare, respond.
  task automatic cycle();
    logic p_rst, p_ir, p_dr, p_dw, p_ack, wr_do, old_irdy;
    logic [31:0] p_ia, p_da, p_dwd, p_mrd, wr_a, wr_d;
    p_rst = rst; p_ir = bus.instr_read; p_ia = bus.instr_addr;
    p_dr = bus.data_read; p_dw = bus.data_write; p_da = bus.data_addr;
    p_dwd = bus.data_wdata; p_ack = bus.mem_ack; p_mrd = bus.mem_rdata;
    wr_do = bus.mem_req && bus.mem_ack && bus.mem_we && !rst;
    wr_a = bus.mem_addr; wr_d = bus.mem_wdata;
    @(posedge clk); #1;
    if (wr_do) mem_arr[midx(wr_a)] = wr_d;

    old_irdy = e_irdy;
    if (p_rst) begin
      m_phase = 0; m_starve = 0; m_port_d = 0;
      e_req = 0; e_we = 0; e_irdy = 0; e_drdy = 0;
      e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
      fw = 0; sg_i = 0; sg_d = 0;
    end else begin
      if (p_ir && !old_irdy) fw = fw + 1;
      e_irdy = 0; e_drdy = 0;
      if (m_phase == 0) begin
        if ((p_dr || p_dw) && !(p_ir && m_starve == STARVE_LIMIT)) begin
          e_req = 1; e_we = p_dw; e_addr = p_da; e_wdata = p_dwd;
          m_port_d = 1; m_phase = 1; sg_d = sg_d + 1;
          m_starve = p_ir ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve) : 0;
        end else if (p_ir) begin
          e_req = 1; e_we = 0; e_addr = p_ia; e_wdata = 0;
          m_port_d = 0; m_phase = 1; sg_i = sg_i + 1; m_starve = 0;
        end else begin
          m_starve = 0;
        end
      end else if (m_phase == 1) begin
        if (p_ack) begin
          e_req = 0; m_phase = 2;
          if (m_port_d) begin
            e_drdy = 1;
            if (!e_we) e_drdata = p_mrd;
          end else begin
            e_irdy = 1; e_irdata = p_mrd;
          end
        end
      end else begin
        m_phase = 0;
      end
    end

    check_eq("mem_req", bus.mem_req, e_req);
    check_eq("mem_we", bus.mem_we, e_we);
    check_eq("mem_addr", bus.mem_addr, e_addr);
    check_eq("mem_wdata", bus.mem_wdata, e_wdata);
    check_eq("instr_ready", bus.instr_ready, e_irdy);
    check_eq("data_ready", bus.data_ready, e_drdy);
    check_eq("instr_rdata", bus.instr_rdata, e_irdata);
    check_eq("data_rdata", bus.data_rdata, e_drdata);
    check_eq("rdy_excl", bus.instr_ready & bus.data_ready, 1'b0);
`ifdef MEM_ARB_STATS_EN
    check_eq("stat_instr", stat_instr_grants, sg_i);
    check_eq("stat_data", stat_data_grants, sg_d);
    check_eq("stat_fwait", stat_fetch_wait, fw);
`endif

    if (bus.mem_req && !prev_req) grant_log.push_back(bus.mem_addr[22]);
    prev_req = bus.mem_req;

    if (!bus.mem_req) begin
      req_seen = 0; ack_cnt = 0;
    end else if (!req_seen) begin
      req_seen = 1; ack_cnt = $urandom_range(lat_max, lat_min);
    end else if (ack_cnt > 0) begin
      ack_cnt--;
    end
    bus.mem_ack   = force_ack | (bus.mem_req && ack_cnt == 0);
    bus.mem_rdata = bus.mem_ack ? mem_arr[midx(bus.mem_addr)] : $urandom();
  endtask

  // Random requesters: hold until ready, occasionally drop after grant.
  task automatic gen_requests(input int i_rate, input int d_rate, input bit drop_en);
    int kind;
    if (e_irdy) begin i_act = 0; i_blk = 0; end
    if (e_drdy) begin d_act = 0; d_blk = 0; end
    if (drop_en && i_act && m_phase == 1 && !m_port_d && $urandom_range(99, 0) < 10) begin
      i_act = 0; i_blk = 1;
    end
    if (drop_en && d_act && m_phase == 1 && m_port_d && $urandom_range(99, 0) < 10) begin
      d_act = 0; d_blk = 1;
    end
    if (!i_act && !i_blk && $urandom_range(99, 0) < i_rate) begin
      i_act = 1;
      bus.instr_addr = 32'h0040_0000 + 32'($urandom_range(7, 0) * 4);
    end
    if (!d_act && !d_blk && $urandom_range(99, 0) < d_rate) begin
      d_act = 1;
      kind = $urandom_range(4, 0);
      bus.data_read  = (kind != 1);
      bus.data_write = (kind == 1) || (kind == 4);
      bus.data_addr  = 32'h1001_0000 + 32'($urandom_range(7, 0) * 4);
      bus.data_wdata = $urandom();
    end
    bus.instr_read = i_act;
    if (!d_act) begin bus.data_read = 0; bus.data_write = 0; end
  endtask

  initial begin : main
    logic [31:0] old_d;
    int rises;
    bit seen;
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom();
    rst = 1;
    bus.instr_read = 1; bus.instr_addr = 32'h0040_0000;
    bus.data_read = 1; bus.data_write = 0; bus.data_addr = 32'h1001_0000;
    bus.data_wdata = 0; bus.mem_ack = 1; bus.mem_rdata = 0;

    // 1. reset with requests active, then a zero-latency fetch
    for (int i = 0; i < 5; i++) cycle();
    check_eq("rst_req", bus.mem_req, 1'b0);
    check_eq("rst_irdy", bus.instr_ready, 1'b0);
    check_eq("rst_drdy", bus.data_ready, 1'b0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    rst = 0; bus.data_read = 0;
    bus.instr_addr = 32'h0040_0000;
    mem_arr[midx(32'h0040_0000)] = 32'h2008_000A;
    lat_min = 0; lat_max = 0;
    cycle();
    check_eq("f_req", bus.mem_req, 1'b1);
    check_eq("f_addr", bus.mem_addr, 32'h0040_0000);
    cycle();
    check_eq("f_rdy", bus.instr_ready, 1'b1);
    check_eq("f_rdata", bus.instr_rdata, 32'h2008_000A);
    check_eq("f_req_drop", bus.mem_req, 1'b0);
    bus.instr_read = 0;
    cycle();
    check_eq("f_pulse", bus.instr_ready, 1'b0);

    // 2. store with three wait cycles
    old_d = e_drdata;
    bus.data_write = 1; bus.data_addr = 32'h1001_0000; bus.data_wdata = 32'hDEAD_BEEF;
    lat_min = 3; lat_max = 3;
    cycle();
    check_eq("s_we", bus.mem_we, 1'b1);
    check_eq("s_addr", bus.mem_addr, 32'h1001_0000);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_eq("s_hold_req", bus.mem_req, 1'b1);
      check_eq("s_hold_addr", bus.mem_addr, 32'h1001_0000);
      check_eq("s_hold_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      check_eq("s_early_rdy", bus.data_ready, 1'b0);
    end
    cycle();
    check_eq("s_rdy", bus.data_ready, 1'b1);
    check_eq("s_rdata_keep", bus.data_rdata, old_d);
    bus.data_write = 0;
    cycle();
    check_eq("s_pulse", bus.data_ready, 1'b0);
    check_eq("s_memwr", mem_arr[midx(32'h1001_0000)], 32'hDEAD_BEEF);

    // 5. read and write together -> one write
    old_d = e_drdata;
    bus.data_read = 1; bus.data_write = 1;
    bus.data_addr = 32'h1001_0004; bus.data_wdata = 32'h0BAD_F00D;
    lat_min = 1; lat_max = 1;
    rises = grant_log.size();
    cycle();
    check_eq("rw_we", bus.mem_we, 1'b1);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cycle();
      seen = bus.data_ready;
    end
    check_eq("rw_done", seen, 1'b1);
    check_eq("rw_rdata_keep", bus.data_rdata, old_d);
    bus.data_read = 0; bus.data_write = 0;
    cycle();
    check_eq("rw_single", grant_log.size() - rises, 1);
    check_eq("rw_memwr", mem_arr[midx(32'h1001_0004)], 32'h0BAD_F00D);

    // 4. reset while a load waits for memory
    bus.data_read = 1; bus.data_addr = 32'h1001_0008;
    lat_min = 6; lat_max = 6;
    cycle();
    cycle();
    rst = 1;
    cycle();
    check_eq("mr_req", bus.mem_req, 1'b0);
    check_eq("mr_drdy", bus.data_ready, 1'b0);
    rst = 0; bus.data_read = 0;
    force_ack = 1; bus.mem_ack = 1;
    cycle();
    check_eq("late_ack_req", bus.mem_req, 1'b0);
    check_eq("late_ack_drdy", bus.data_ready, 1'b0);
    force_ack = 0; bus.mem_ack = 0;
    bus.instr_read = 1; bus.instr_addr = 32'h0040_0010;
    lat_min = 0; lat_max = 2;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      cycle();
      seen = bus.instr_ready;
    end
    check_eq("mr_fetch_done", seen, 1'b1);
    check_eq("mr_fetch_data", bus.instr_rdata, mem_arr[midx(32'h0040_0010)]);
    bus.instr_read = 0;
    cycle();

    // 3/6. contention from a fresh reset
    rst = 1;
    cycle(); cycle();
    rst = 0;
    i_act = 0; d_act = 0; i_blk = 0; d_blk = 0;
    grant_log.delete();
    for (int k = 0; k < 300 && grant_log.size() < 10; k++) begin
      gen_requests(100, 100, 0);
      cycle();
    end
    check_eq("cont_grants", grant_log.size(), 10);
    for (int n = 0; n < 10 && n < grant_log.size(); n++)
      check_eq($sformatf("cont_order%0d", n), grant_log[n], (n % 5) == 4);
`ifdef MEM_ARB_STATS_EN
    check_eq("cont_stat_d", stat_data_grants, 32'd8);
    check_eq("cont_stat_i", stat_instr_grants, 32'd2);
    check_eq("cont_stat_fw", stat_fetch_wait, fw);
`endif

    // randomized traffic
    lat_min = 0; lat_max = 3;
    for (int k = 0; k < 800; k++) begin
      gen_requests(40, 50, 1);
      cycle();
    end
    bus.instr_read = 0; bus.data_read = 0; bus.data_write = 0;
    for (int k = 0; k < 10; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data port.
- Sits between the pipeline inside mips_system and the memory model.
- Serialises instruction reads and data reads/writes onto one memory handshake; data has priority, with a starvation guard for fetch.
- Returns per-port ready pulses; the pipeline stalls while a port's request is outstanding.

Parameters:
- ADDR_W, 32, address width of all buses.
- DATA_W, 32, data width of all buses.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced (must be ≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_read  in  1  fetch request; held until instr_ready.
- instr_addr  in  ADDR_W  fetch address; stable while instr_read is high.
- instr_rdata  out  DATA_W  fetched word; valid when instr_ready is high.
- instr_ready  out  1  one-cycle completion pulse for fetch.
- data_read  in  1  load request; held until data_ready.
- data_write  in  1  store request; held until data_ready.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load result; valid when data_ready is high.
- data_ready  out  1  one-cycle completion pulse for load/store.
- mem_req  out  1  memory access request; held until mem_ack.
- mem_we  out  1  1 = write, 0 = read; stable with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory; arbitrary latency ≥0 cycles after mem_req rises.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; starvation counter 0. A reset mid-transaction abandons it: no ready pulse, and mem_req drops in the next cycle.
- FSM states are IDLE, BUSY_I, BUSY_D and DONE. All outputs are registered.
- IDLE, arbitration rules:
  - No request: stay in IDLE.
  - Only data pending: grant data.
  - Only instr pending: grant instr.
  - Both pending: grant data unless starve_cnt == STARVE_LIMIT, in which case grant instr.
- On a grant, latch address, we and wdata into mem_* registers and assert mem_req next cycle. State becomes BUSY_I or BUSY_D.
- BUSY_x: hold mem_req/mem_addr/mem_we/mem_wdata stable until mem_ack is sampled high. On mem_ack, in the same edge:
  - drop mem_req;
  - capture mem_rdata into x_rdata (loads and fetches only; data_rdata is unchanged on a write);
  - pulse x_ready for exactly one cycle;
  - go to DONE.
- DONE: one bubble cycle so the requester can deassert or update its request. Then return to IDLE; requests are not sampled in DONE.
- Minimum latency: request seen at edge N → mem_req high after N → mem_ack sampled at N+1 → ready high after N+1 → next grant at N+3. That gives 2 cycles request-to-ready and one access per 3 cycles at best.
- Starvation counter:
  - Increments on each data grant while instr_read is high, saturating at STARVE_LIMIT.
  - Clears on each instr grant and whenever instr_read is low in IDLE.
- data_read and data_write both high: treated as a write; data_rdata is unchanged.
- Requester drops its request after grant: the transaction still completes and the ready pulse is still issued.
- x_rdata holds its last value until overwritten.
- mem_ack while IDLE or DONE is ignored.
- instr_ready and data_ready are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds output ports stat_instr_grants, stat_data_grants and stat_fetch_wait, each 32 bits, saturating, cleared by rst.
  - stat_instr_grants and stat_data_grants count grants.
  - stat_fetch_wait counts cycles where instr_read is high and instr_ready is low.
- When undefined, these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- Package mips_mem_pkg holds the ADDR_W/DATA_W defaults, the arb_state_t enum {IDLE, BUSY_I, BUSY_D, DONE}, and the grant-source encoding.
- One natural sub-module, mem_arb_stats: the saturating counter bank, instantiated only under MEM_ARB_STATS_EN.

Test Plan:
1. Reset: hold rst for 5 cycles with requests active → all outputs 0. Release rst, instr_read=1, addr=0x00400000, memory acks 0 cycles after mem_req → mem_req high for 1 cycle with mem_addr=0x00400000, then instr_ready pulses with the memory word (e.g. 0x2008000A).
2. Store with 3-cycle memory latency: data_write=1, addr=0x10010000, wdata=0xDEADBEEF → mem_we=1, address/data stable for all 3 wait cycles, data_ready pulses once, data_rdata unchanged.
3. Contention, STARVE_LIMIT=4: instr_read and data_read held high continuously, data re-requested after each ready → grant order D,D,D,D,I,D,D,D,D,I…; the fetch is never starved beyond 4 data grants.
4. Mid-access reset: rst asserted while in BUSY_D before mem_ack → mem_req=0 and data_ready=0 after the reset edge. A late mem_ack is ignored, and the next fetch completes normally.
5. Simultaneous data_read and data_write with addr=0x10010004 → a single write access (mem_we=1); data_rdata holds its prior value.
6. With MEM_ARB_STATS_EN: run scenario 3 for 10 grants → stat_data_grants=8 and stat_instr_grants=2; stat_fetch_wait equals the count of fetch-pending cycles without instr_ready.
